// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: the upstream immediate stream and the
// downstream extended stream, with the pipe on the slave modport.
interface imm_extend_pipe_if #(
  parameter int N     = 16,
  parameter int M     = 32,
  parameter int TAG_W = 5
);
  // Both streams: a beat transfers on a rising clk edge where valid and ready
  // are both high. The payload is only meaningful while valid is high. Once
  // raised, out_valid and its payload hold until accepted. in_valid may drop
  // at any time.
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender feeding a 2-entry FIFO. Values are stored
// already extended. Define IMMEXT_STATS_EN to add push and stall counters.
module imm_extend_pipe #(
  parameter int N     = 16,
  parameter int M     = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  imm_extend_pipe_if.slave  bus
`ifdef IMMEXT_STATS_EN
  ,
  output logic [15:0]       stat_push_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);

  if (M <= N + 2) begin : g_bad_params
    $error("imm_extend_pipe: M must be greater than N+2");
  end

  logic [M-1:0]     data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [M-1:0]     ext;
  logic             push;
  logic             pop;

  always_comb begin
    ext = '0;
    case (bus.in_mode)
      2'b00:   ext = {{(M-N){bus.in_imm[N-1]}}, bus.in_imm};
      2'b01:   ext = {{(M-N){1'b0}}, bus.in_imm};
      2'b10:   ext = {bus.in_imm, {(M-N){1'b0}}};
      default: ext = {{(M-N-2){bus.in_imm[N-1]}}, bus.in_imm, 2'b00};
    endcase
  end

  // Both handshake outputs come from registered count only.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = data_q[rd_ptr];
  assign bus.out_tag   = tag_q[rd_ptr];

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= ext;
        tag_q[wr_ptr]  <= bus.in_tag;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IMMEXT_STATS_EN
  logic [15:0] push_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else if (flush) begin
      push_cnt_q  <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (push && (push_cnt_q != 16'hFFFF)) begin
        push_cnt_q <= push_cnt_q + 16'd1;
      end
      if (bus.out_valid && !bus.out_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign stat_push_cnt  = push_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  // Statistics counters are absent from this build.
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus a random
// phase, checked every cycle against a queue model of the buffer.
module tb_imm_extend_pipe;
  localparam int N     = 16;
  localparam int M     = 32;
  localparam int TAG_W = 5;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;

  imm_extend_pipe_if #(.N(N), .M(M), .TAG_W(TAG_W)) bus ();

`ifdef IMMEXT_STATS_EN
  logic [15:0] stat_push_cnt;
  logic [15:0] stat_stall_cnt;
`endif

  imm_extend_pipe #(.N(N), .M(M), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .bus            (bus.slave)
`ifdef IMMEXT_STATS_EN
    ,
    .stat_push_cnt  (stat_push_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [M+TAG_W-1:0] exp_q[$];

  function automatic logic [M-1:0] ref_ext(input logic [N-1:0] imm, input logic [1:0] mode);
    longint u;
    longint s;
    longint r;
    u = longint'(imm);
    s = imm[N-1] ? (u - (longint'(1) <<< N)) : u;
    case (mode)
      2'b00:   r = s;
      2'b01:   r = u;
      2'b10:   r = u * (longint'(1) <<< (M - N));
      default: r = s * 4;
    endcase
    return r[M-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = bus.in_valid && (exp_q.size() != 2);
      do_pop  = (exp_q.size() != 0) && bus.out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({ref_ext(bus.in_imm, bus.in_mode), bus.in_tag});
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(exp_q.size() != 2));
    if (exp_q.size() != 0) begin
      check("out_data", 64'(bus.out_data), 64'(exp_q[0][M+TAG_W-1:TAG_W]));
      check("out_tag", 64'(bus.out_tag), 64'(exp_q[0][TAG_W-1:0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge following the accepting edge
  // with in_valid still high.
  task automatic push_item(input logic [N-1:0] imm, input logic [1:0] mode,
                           input logic [TAG_W-1:0] tag);
    bit acc;
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    do begin
      acc = bus.in_ready;
      @(negedge clk);
      waited++;
    end while (!acc && waited < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: actual=not_accepted expected=accepted at %0t", $time);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    flush        = 1'b0;
  endtask

  // ---------------- directed literals ----------------
  logic [N-1:0] lit_imm  [6] = '{16'h000A, 16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0003};
  logic [1:0]   lit_mode [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [M-1:0] lit_exp  [6] = '{32'h0000000A, 32'hFFFF8000, 32'h00008000,
                                 32'h12340000, 32'hFFFFFFFC, 32'h0000000C};

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_mode   = 2'b00;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_out_tag", 64'(bus.out_tag), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Modes: one push per cycle, each visible the cycle after its push.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_item(lit_imm[i], lit_mode[i], TAG_W'(i));
      check("mode_data", 64'(bus.out_data), 64'(lit_exp[i]));
      check("mode_tag", 64'(bus.out_tag), 64'(i));
    end
    idle_inputs();
    repeat (2) @(negedge clk);

    // Simultaneous push and pop with one entry resident.
    push_item(16'h0101, 2'b01, 5'd20);
    for (int i = 0; i < 10; i++) begin
      logic [TAG_W-1:0] t;
      t = TAG_W'(i);
      push_item(N'($urandom), 2'($urandom_range(0, 3)), t);
      check("pp_in_ready", 64'(bus.in_ready), 64'h1);
      check("pp_out_tag", 64'(bus.out_tag), 64'(t));
    end
    idle_inputs();
    repeat (2) @(negedge clk);

    // Flush with two entries and a concurrent offered item and pop.
    bus.out_ready = 1'b0;
    push_item(16'h0011, 2'b00, 5'd1);
    push_item(16'h0022, 2'b00, 5'd2);
    bus.in_tag    = 5'd9;
    bus.in_valid  = 1'b1;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.out_ready = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'h0);
    check("flush_in_ready", 64'(bus.in_ready), 64'h1);
    @(negedge clk);
    check("flush_not_stored", 64'(bus.out_valid), 64'h0);

    // Backpressure: third tag held upstream until downstream drains.
    push_item(16'h0001, 2'b01, 5'd1);
    push_item(16'h0002, 2'b01, 5'd2);
    bus.in_imm = 16'h0003;
    bus.in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 64'(bus.in_ready), 64'h0);
      check("bp_out_tag", 64'(bus.out_tag), 64'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("bp_drain0", 64'(bus.out_tag), 64'd1);
    @(negedge clk);
    check("bp_drain1", 64'(bus.out_tag), 64'd2);
    @(negedge clk);
    check("bp_drain2", 64'(bus.out_tag), 64'd3);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_imm    = N'($urandom);
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.in_tag    = TAG_W'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

`ifdef IMMEXT_STATS_EN
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_item(N'(i), 2'b00, TAG_W'(i));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("stat_push_cnt", 64'(stat_push_cnt), 64'd5);
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'd3);
    force dut.push_cnt_q = 16'hFFFF;
    #1;
    release dut.push_cnt_q;
    @(negedge clk);
    bus.out_ready = 1'b1;
    push_item(16'h0055, 2'b01, 5'd5);
    bus.in_valid = 1'b0;
    check("stat_push_sat", 64'(stat_push_cnt), 64'hFFFF);
    repeat (2) @(negedge clk);
`endif

    // Asynchronous reset between edges with two entries buffered.
    bus.out_ready = 1'b0;
    push_item(16'h00AA, 2'b01, 5'd11);
    push_item(16'h00BB, 2'b01, 5'd12);
    bus.in_valid = 1'b0;
    check("pre_rst_full", 64'(bus.in_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'h0);
    check("arst_in_ready", 64'(bus.in_ready), 64'h1);
    check("arst_out_data", 64'(bus.out_data), 64'h0);
    check("arst_out_tag", 64'(bus.out_tag), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    push_item(16'h00FF, 2'b01, 5'd7);
    bus.in_valid = 1'b0;
    check("post_rst_data", 64'(bus.out_data), 64'h000000FF);
    check("post_rst_tag", 64'(bus.out_tag), 64'd7);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit. It is the successor to the combinational sign extender and feeds the ALU-B and branch-target paths of the pipelined datapath.
- Supports four extension modes: sign, zero, upper (LUI) and branch-offset.
- Input and output each use a valid/ready handshake.
- A 2-entry skid buffer lets the upstream stage keep issuing while downstream stalls.

Parameters:
- N, 16, input immediate width; N >= 2.
- M, 32, output width; M > N + 2.
- TAG_W, 5, width of the sideband tag (e.g. destination register) carried alongside each immediate.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of buffered entries
- in_valid  input  1  upstream has an immediate
- in_ready  output  1  unit can accept this cycle
- in_imm  input  N  raw immediate field
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch offset
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts
- out_data  output  M  extended value
- out_tag  output  TAG_W  tag of head entry

Behaviour:
- Extension is computed combinationally at the input and stored already extended. Output is driven from registers only; there is no input-to-output combinational path.
  - mode 00: {(M-N) copies of imm[N-1], imm}.
  - mode 01: {(M-N) zeros, imm}.
  - mode 10: imm in bits [M-1:M-N], lower M-N bits zero.
  - mode 11: sign-extend to M, shift left 2, keep low M bits; bits [1:0] are zero.
- Storage: 2-entry FIFO (entry regs, rd_ptr, wr_ptr, count 0..2).
  - in_ready = (count != 2), derived from registered count.
  - out_valid = (count != 0).
  - out_data/out_tag = head entry.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: item pushed at edge k is visible on out_* in the cycle after edge k, when the buffer was empty. Throughput is 1 item/cycle while out_ready is held high.
- count=0: push only; pop impossible.
- count=1: push & pop same edge leaves count=1, and the new item becomes head.
- count=2: in_ready=0, so no push; pop moves to count=1.
- Pointers wrap modulo 2. Order is strictly FIFO.
- out_* must hold stable while out_valid=1 and out_ready=0.
- Upstream may drop in_valid at will. in_imm/in_mode/in_tag are only sampled on push.
- flush=1 at an edge:
  - count, rd_ptr and wr_ptr are set to 0; any concurrent push or pop is discarded.
  - Next cycle out_valid=0 and in_ready=1.
  - Entry data registers are not cleared.
- Reset (asynchronous assert, any time, including mid-transfer):
  - count=0 and pointers=0, so in_ready=1 and out_valid=0.
  - Entry registers cleared, so out_data=0 and out_tag=0.
  - Release is synchronous to clk, handled by the external reset synchroniser.
- Illegal parameter set (M <= N+2): elaboration error via generate-time check.

Optional Feature:
- Macro IMMEXT_STATS_EN.
- When defined, adds output stat_push_cnt (16 bits) and output stat_stall_cnt (16 bits).
  - stat_push_cnt increments on every push.
  - stat_stall_cnt increments every cycle with out_valid=1 and out_ready=0.
  - Both counters saturate at 0xFFFF.
  - Both clear on rst_n and on flush.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Modes, N=16, M=32, out_ready=1, one push per cycle. Each output appears one cycle after its push, in order:
  - in_imm 0x000A mode 00 -> 0x0000000A.
  - in_imm 0x8000 mode 00 -> 0xFFFF8000.
  - in_imm 0x8000 mode 01 -> 0x00008000.
  - in_imm 0x1234 mode 10 -> 0x12340000.
  - in_imm 0xFFFF mode 11 -> 0xFFFFFFFC.
  - in_imm 0x0003 mode 11 -> 0x0000000C.
- Backpressure: out_ready=0, offer tags 1, 2, 3 back-to-back.
  - in_ready drops after the 2nd push; tag 3 is held upstream; out_tag stays 1.
  - Raise out_ready: tags emerge 1, 2, 3 on consecutive cycles.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, in_ready stays 1, no item lost or duplicated (scoreboard).
- Flush with count=2 and concurrent in_valid=1: next cycle out_valid=0, in_ready=1, and the concurrent item is not stored.
- Reset mid-stream: assert rst_n=0 asynchronously between edges with count=2. Outputs immediately go out_valid=0, in_ready=1, out_data=0. After release, normal operation resumes with a fresh item.
- IMMEXT_STATS_EN build: 5 pushes, then 3 stalled cycles -> stat_push_cnt=5, stat_stall_cnt=3. Force 0xFFFF and push again -> stat_push_cnt remains 0xFFFF.
